// File: rtl/hazard_stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_ctrl_pkg
// Description : Shared types for the pipeline stall/flush controller.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_stall_ctrl_pkg;

    localparam int REG_AW_DEFAULT = 5;
    localparam int STAT_W_DEFAULT = 16;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        HZ_NONE     = 3'd0,
        HZ_LW_BR    = 3'd1,
        HZ_LW       = 3'd2,
        HZ_ALU_BR   = 3'd3,
        HZ_MEMLW_BR = 3'd4
    } hz_class_t;

    // Bubble cycles each hazard class needs before ID operands are valid.
    function automatic logic [1:0] hz_stalls(input hz_class_t c);
        case (c)
            HZ_LW_BR:    return 2'd2;
            HZ_LW:       return 2'd1;
            HZ_ALU_BR:   return 2'd1;
            HZ_MEMLW_BR: return 2'd1;
            default:     return 2'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_stall_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_ctrl_if
// Description : Pipeline-side signals seen and driven by the stall controller.
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_stall_ctrl_if #(
    parameter int REG_AW = 5,
    parameter int STAT_W = 16
);
    logic [REG_AW-1:0] id_rs;
    logic [REG_AW-1:0] id_rt;
    logic              id_uses_rt;
    logic              id_is_branch;
    logic              id_branch_taken;
    logic [REG_AW-1:0] ex_dst;
    logic              ex_reg_write;
    logic              ex_mem_read;
    logic [REG_AW-1:0] mem_dst;
    logic              mem_mem_read;
    logic              hold;
    logic              pc_write;
    logic              ifid_write;
    logic              idex_noop;
    logic              ifid_flush;
    logic              stalling;
    logic [STAT_W-1:0] stall_cycles;

    modport master (
        output id_rs, id_rt, id_uses_rt, id_is_branch, id_branch_taken,
               ex_dst, ex_reg_write, ex_mem_read, mem_dst, mem_mem_read, hold,
        input  pc_write, ifid_write, idex_noop, ifid_flush, stalling, stall_cycles
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, id_is_branch, id_branch_taken,
               ex_dst, ex_reg_write, ex_mem_read, mem_dst, mem_mem_read, hold,
        output pc_write, ifid_write, idex_noop, ifid_flush, stalling, stall_cycles
    );

endinterface
`default_nettype wire

// File: rtl/hazard_stall_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : hazard_detect
// Description : Combinational ID-vs-EX/MEM hazard classification.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEFAULT
) (
    input  wire logic [REG_AW-1:0] id_rs_i,
    input  wire logic [REG_AW-1:0] id_rt_i,
    input  wire logic              id_uses_rt_i,
    input  wire logic              id_is_branch_i,
    input  wire logic [REG_AW-1:0] ex_dst_i,
    input  wire logic              ex_reg_write_i,
    input  wire logic              ex_mem_read_i,
    input  wire logic [REG_AW-1:0] mem_dst_i,
    input  wire logic              mem_mem_read_i,
    output hz_class_t              class_o,
    output logic [1:0]             n_o
);

    logic w_match_ex;
    logic w_match_mem;

    // $0 is hardwired, so a write to it can never feed a later reader.
    assign w_match_ex  = (ex_dst_i != '0) &&
                         ((ex_dst_i == id_rs_i) || (id_uses_rt_i && (ex_dst_i == id_rt_i)));
    assign w_match_mem = (mem_dst_i != '0) &&
                         ((mem_dst_i == id_rs_i) || (id_uses_rt_i && (mem_dst_i == id_rt_i)));

    always_comb begin
        class_o = HZ_NONE;
        if (ex_mem_read_i && w_match_ex && id_is_branch_i) begin
            class_o = HZ_LW_BR;
        end else if (ex_mem_read_i && w_match_ex) begin
            class_o = HZ_LW;
        end else if (ex_reg_write_i && w_match_ex && id_is_branch_i) begin
            class_o = HZ_ALU_BR;
        end else if (mem_mem_read_i && w_match_mem && id_is_branch_i) begin
            class_o = HZ_MEMLW_BR;
        end
    end

    assign n_o = hz_stalls(class_o);

endmodule
`default_nettype wire

// File: rtl/hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_ctrl
// Description : Stall/flush sequencer with bubble FSM and stall statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_AW_DEFAULT,
    parameter int STAT_W = STAT_W_DEFAULT
) (
    input  wire logic        clk,
    input  wire logic        rst,
    hazard_stall_ctrl_if.slave hz
);

    state_t              state_q;
    logic [1:0]          rem_cnt_q;
    logic [STAT_W-1:0]   stall_cycles_q;
    logic [STAT_W-1:0]   stall_cycles_d;

    hz_class_t           w_class;
    logic [1:0]          w_n;
    logic                w_hazard;
    logic                w_pc_write;
    logic                w_ifid_write;
    logic                w_idex_noop;
    logic                w_ifid_flush;
    logic                w_stalling;

    hazard_detect #(
        .REG_AW (REG_AW)
    ) u_detect (
        .id_rs_i        (hz.id_rs),
        .id_rt_i        (hz.id_rt),
        .id_uses_rt_i   (hz.id_uses_rt),
        .id_is_branch_i (hz.id_is_branch),
        .ex_dst_i       (hz.ex_dst),
        .ex_reg_write_i (hz.ex_reg_write),
        .ex_mem_read_i  (hz.ex_mem_read),
        .mem_dst_i      (hz.mem_dst),
        .mem_mem_read_i (hz.mem_mem_read),
        .class_o        (w_class),
        .n_o            (w_n)
    );

    assign w_hazard = (state_q == ST_IDLE) && (w_class != HZ_NONE);

    // Enables are combinational so the bubble lands in the detection cycle.
    always_comb begin
        w_pc_write   = 1'b0;
        w_ifid_write = 1'b0;
        w_idex_noop  = 1'b0;
        w_ifid_flush = 1'b0;
        w_stalling   = 1'b0;
        if (rst) begin
            w_idex_noop = 1'b1;
        end else if (hz.hold) begin
            w_stalling = (state_q == ST_STALL);
        end else if (state_q == ST_STALL) begin
            w_idex_noop = 1'b1;
            w_stalling  = 1'b1;
        end else if (w_hazard) begin
            w_idex_noop = 1'b1;
        end else begin
            w_pc_write   = 1'b1;
            w_ifid_write = 1'b1;
            w_ifid_flush = hz.id_is_branch && hz.id_branch_taken;
        end
    end

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (w_idex_noop && (stall_cycles_q != {STAT_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + STAT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            rem_cnt_q      <= 2'd0;
            stall_cycles_q <= '0;
        end else if (!hz.hold) begin
            stall_cycles_q <= stall_cycles_d;
            case (state_q)
                ST_IDLE: begin
                    // Single-bubble hazards stay in IDLE and are re-evaluated next cycle.
                    if (w_hazard && (w_n == 2'd2)) begin
                        state_q   <= ST_STALL;
                        rem_cnt_q <= 2'd1;
                    end
                end
                ST_STALL: begin
                    if (rem_cnt_q == 2'd1) begin
                        state_q   <= ST_IDLE;
                        rem_cnt_q <= 2'd0;
                    end else begin
                        rem_cnt_q <= rem_cnt_q - 2'd1;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    rem_cnt_q <= 2'd0;
                end
            endcase
        end
    end

    assign hz.pc_write     = w_pc_write;
    assign hz.ifid_write   = w_ifid_write;
    assign hz.idex_noop    = w_idex_noop;
    assign hz.ifid_flush   = w_ifid_flush;
    assign hz.stalling     = w_stalling;
    assign hz.stall_cycles = stall_cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_stall_ctrl
// Description : Self-checking bench for hazard_stall_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_ctrl;

    localparam int REG_AW = 5;
    localparam int STAT_W = 4;
    localparam int SAT    = 15;

    typedef struct {
        string       name;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        urt;
        logic        br;
        logic        tk;
        logic [4:0]  exd;
        logic        exrw;
        logic        exmr;
        logic [4:0]  mdst;
        logic        mmr;
        logic        hld;
        logic [4:0]  exp_o;   // {pc_write, ifid_write, idex_noop, ifid_flush, stalling}
        int          exp_cnt;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass   = 0;
    int   n_checks = 0;
    vec_t tbl[16];
    vec_t sb[$];

    hazard_stall_ctrl_if #(.REG_AW(REG_AW), .STAT_W(STAT_W)) bus ();

    hazard_stall_ctrl #(.REG_AW(REG_AW), .STAT_W(STAT_W)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input string nm, input logic [4:0] rs, input logic [4:0] rt,
                                input logic urt, input logic br, input logic tk,
                                input logic [4:0] exd, input logic exrw, input logic exmr,
                                input logic [4:0] mdst, input logic mmr, input logic hld,
                                input logic [4:0] exp_o, input int exp_cnt);
        vec_t v;
        v.name = nm; v.rs = rs; v.rt = rt; v.urt = urt; v.br = br; v.tk = tk;
        v.exd = exd; v.exrw = exrw; v.exmr = exmr; v.mdst = mdst; v.mmr = mmr;
        v.hld = hld; v.exp_o = exp_o; v.exp_cnt = exp_cnt;
        return v;
    endfunction

    task automatic drive(input vec_t v);
        bus.id_rs           = v.rs;
        bus.id_rt           = v.rt;
        bus.id_uses_rt      = v.urt;
        bus.id_is_branch    = v.br;
        bus.id_branch_taken = v.tk;
        bus.ex_dst          = v.exd;
        bus.ex_reg_write    = v.exrw;
        bus.ex_mem_read     = v.exmr;
        bus.mem_dst         = v.mdst;
        bus.mem_mem_read    = v.mmr;
        bus.hold            = v.hld;
    endtask

    task automatic compare(input vec_t v);
        logic [4:0] got;
        got = {bus.pc_write, bus.ifid_write, bus.idex_noop, bus.ifid_flush, bus.stalling};
        n_checks++;
        if (got === v.exp_o && int'(bus.stall_cycles) == v.exp_cnt) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got pc/ifid/noop/flush/stall=%b cnt=%0d, expected %b cnt=%0d",
                     v.name, got, bus.stall_cycles, v.exp_o, v.exp_cnt);
        end
    endtask

    // Drive just after the edge, score the combinational outputs on the falling edge.
    task automatic cycle(input vec_t v);
        vec_t e;
        @(posedge clk);
        #1;
        drive(v);
        sb.push_back(v);
        @(negedge clk);
        e = sb.pop_front();
        compare(e);
    endtask

    initial begin
        vec_t v;
        tbl[0]  = mk("idle",          0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 5'b11000, 0);
        tbl[1]  = mk("lw_use",        5, 0, 0, 0, 0,  5, 1, 1,  0, 0, 0, 5'b00100, 0);
        tbl[2]  = mk("after_lw_use",  5, 0, 0, 0, 0,  0, 0, 0,  5, 0, 0, 5'b11000, 1);
        tbl[3]  = mk("lw_br_1",       5, 0, 1, 1, 1,  5, 1, 1,  0, 0, 0, 5'b00100, 1);
        tbl[4]  = mk("lw_br_2",       5, 0, 1, 1, 1,  5, 1, 1,  0, 0, 0, 5'b00101, 2);
        tbl[5]  = mk("br_taken",      5, 0, 1, 1, 1,  0, 0, 0,  0, 0, 0, 5'b11010, 3);
        tbl[6]  = mk("zero_reg",      0, 0, 0, 0, 0,  0, 1, 1,  0, 0, 0, 5'b11000, 3);
        tbl[7]  = mk("rt_unused",     3, 7, 0, 0, 0,  7, 1, 1,  0, 0, 0, 5'b11000, 3);
        tbl[8]  = mk("rt_used",       3, 7, 1, 0, 0,  7, 1, 1,  0, 0, 0, 5'b00100, 3);
        tbl[9]  = mk("alu_br",        9, 0, 1, 1, 1,  9, 1, 0,  0, 0, 0, 5'b00100, 4);
        tbl[10] = mk("alu_fwd",       9, 0, 0, 0, 0,  9, 1, 0,  0, 0, 0, 5'b11000, 5);
        tbl[11] = mk("memlw_br",      1, 4, 1, 1, 0,  0, 0, 0,  4, 1, 0, 5'b00100, 5);
        tbl[12] = mk("memlw_fwd",     4, 0, 0, 0, 0,  0, 0, 0,  4, 1, 0, 5'b11000, 6);
        tbl[13] = mk("hold_hazard",   5, 0, 1, 1, 1,  5, 1, 1,  0, 0, 1, 5'b00000, 6);
        tbl[14] = mk("hold_branch",   0, 0, 1, 1, 1,  0, 0, 0,  0, 0, 1, 5'b00000, 6);
        tbl[15] = mk("post_hold",     0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 5'b11000, 6);

        drive(mk("rst", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00100, 0));
        #1;
        compare(mk("reset_state", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00100, 0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) begin
            cycle(tbl[i]);
        end

        // Hold for three cycles after the first bubble of a two-bubble stall.
        cycle(mk("hs_bubble1",   5, 0, 1, 1, 1,  5, 1, 1,  0, 0, 0, 5'b00100, 6));
        for (int i = 0; i < 3; i++) begin
            cycle(mk("hs_hold",  5, 0, 1, 1, 1,  5, 1, 1,  0, 0, 1, 5'b00001, 7));
        end
        cycle(mk("hs_bubble2",   5, 0, 1, 1, 1,  5, 1, 1,  0, 0, 0, 5'b00101, 7));
        cycle(mk("hs_resume",    0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 5'b11000, 8));

        // Asynchronous reset while in STALL.
        cycle(mk("rs_bubble1",   5, 0, 1, 1, 1,  5, 1, 1,  0, 0, 0, 5'b00100, 8));
        cycle(mk("rs_in_stall",  5, 0, 1, 1, 1,  5, 1, 1,  0, 0, 0, 5'b00101, 9));
        v = mk("rs_forced",      0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 5'b00100, 0);
        drive(v);
        rst = 1'b1;
        #1;
        compare(v);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        cycle(mk("rs_no_residual", 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 5'b11000, 0));

        // Back-to-back single bubbles push the statistic into saturation.
        for (int i = 0; i < 18; i++) begin
            cycle(mk("sat_bubble", 6, 0, 0, 0, 0,  6, 1, 1,  0, 0, 0, 5'b00100,
                     (i < SAT) ? i : SAT));
        end
        cycle(mk("sat_hold_val", 0, 0, 0, 0, 0,  0, 0, 0,  0, 0, 0, 5'b11000, SAT));

        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
